// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code encoding and the packed result record
// carried through the result FIFO.
package alu_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      OP_AND = 3'd0,
      OP_OR  = 3'd1,
      OP_XOR = 3'd2,
      OP_NOR = 3'd3,
      OP_ADD = 3'd4,
      OP_SUB = 3'd5,
      OP_SLT = 3'd6,
      OP_SLL = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic [DATA_W-1:0] f;
      logic              zf;
      logic              of;
   } alu_res_t;

endpackage

// File: rtl/alu_stream_if.sv
// Request/result bus of alu_stream; the slave modport is the ALU side.
interface alu_stream_if;
   import alu_pkg::*;

   // Valid/ready: a transfer happens on the rising edge where valid && ready;
   // the source holds its payload stable while valid=1 and ready=0.
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_op;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_f;
   logic              out_zf;
   logic              out_of;

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_f, out_zf, out_of
   );

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_f, out_zf, out_of
   );

endinterface

// File: rtl/alu_core.sv
// Purely combinational 32-bit ALU: A, B, op -> F, zero flag, signed overflow.
module alu_core
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  alu_op_e           op,
   output logic [DATA_W-1:0] f,
   output logic              zf,
   output logic              of
);

   localparam int SH_W = $clog2(DATA_W);

   // One extra bit keeps the carry (add) or borrow (sub) out of the MSB.
   logic [DATA_W:0] wide;

   always_comb begin
      f    = '0;
      of   = 1'b0;
      wide = '0;
      case (op)
         OP_AND: f = a & b;
         OP_OR:  f = a | b;
         OP_XOR: f = a ^ b;
         OP_NOR: f = ~(a | b);
         OP_ADD: begin
            wide = {1'b0, a} + {1'b0, b};
            f    = wide[DATA_W-1:0];
            of   = a[DATA_W-1] ^ b[DATA_W-1] ^ wide[DATA_W-1] ^ wide[DATA_W];
         end
         OP_SUB: begin
            wide = {1'b0, a} - {1'b0, b};
            f    = wide[DATA_W-1:0];
            of   = a[DATA_W-1] ^ b[DATA_W-1] ^ wide[DATA_W-1] ^ wide[DATA_W];
         end
         OP_SLT: f = {{(DATA_W-1){1'b0}}, (a < b)};
         OP_SLL: f = (a >= DATA_W) ? '0 : (b << a[SH_W-1:0]);
         default: f = '0;
      endcase
   end

   assign zf = (f == '0);

endmodule

// File: rtl/alu_stream.sv
// Streaming ALU: each accepted request is evaluated and queued in a small
// result FIFO; accepted-op and overflow counters saturate and clear on cnt_clr.
module alu_stream
   import alu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   alu_stream_if.slave      bus,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] op_cnt,
   output logic [CNT_W-1:0] ovf_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   alu_res_t          mem_q [DEPTH];
   alu_res_t          mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              in_ready_q, in_ready_d;
   logic [CNT_W-1:0]  op_cnt_q, op_cnt_d;
   logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

   logic [DATA_W-1:0] core_f;
   logic              core_zf, core_of;
   alu_res_t          res, head;
   logic              push, pop, out_valid;

   alu_core u_core (
      .a  (bus.in_a),
      .b  (bus.in_b),
      .op (alu_op_e'(bus.in_op)),
      .f  (core_f),
      .zf (core_zf),
      .of (core_of)
   );

   assign res       = '{f: core_f, zf: core_zf, of: core_of};
   assign out_valid = (occ_q != '0);
   assign push      = bus.in_valid && in_ready_q;
   assign pop       = out_valid && bus.out_ready;

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      occ_d     = occ_q;
      op_cnt_d  = op_cnt_q;
      ovf_cnt_d = ovf_cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = res;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
      // Registered ready: depends only on next occupancy, never on out_ready combinationally.
      in_ready_d = (occ_d != OCC_FULL);
      if (cnt_clr) begin
         op_cnt_d  = '0;
         ovf_cnt_d = '0;
      end else if (push) begin
         if (op_cnt_q != '1) op_cnt_d = op_cnt_q + CNT_W'(1);
         if (core_of && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         in_ready_q <= 1'b1;
         op_cnt_q   <= '0;
         ovf_cnt_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         in_ready_q <= in_ready_d;
         op_cnt_q   <= op_cnt_d;
         ovf_cnt_q  <= ovf_cnt_d;
      end
   end

   // Storage needs no reset: outputs are masked to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head          = mem_q[rd_ptr_q];
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid;
   assign bus.out_f     = out_valid ? head.f  : '0;
   assign bus.out_zf    = out_valid ? head.zf : 1'b0;
   assign bus.out_of    = out_valid ? head.of : 1'b0;
   assign op_cnt        = op_cnt_q;
   assign ovf_cnt       = ovf_cnt_q;

endmodule

// File: tb/tb_alu_stream.sv
// Bench for alu_stream: directed ALU vectors, backpressure, reset, counter
// clear/saturation and a random stream against an independent ALU model.
module tb_alu_stream;

   localparam int DEPTH = 2;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             cnt_clr;
   logic [CNT_W-1:0] op_cnt;
   logic [CNT_W-1:0] ovf_cnt;

   alu_stream_if bus ();

   alu_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .cnt_clr (cnt_clr),
      .op_cnt  (op_cnt),
      .ovf_cnt (ovf_cnt)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached with %0d entries pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Result record {F, ZF, OF}; overflow from operand/result signs.
   function automatic logic [33:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] f;
      logic        ov;
      f  = 32'h0;
      ov = 1'b0;
      case (op)
         3'd0: f = a & b;
         3'd1: f = a | b;
         3'd2: f = a ^ b;
         3'd3: f = ~(a | b);
         3'd4: begin f = a + b; ov = (a[31] == b[31]) && (f[31] != a[31]); end
         3'd5: begin f = a - b; ov = (a[31] != b[31]) && (f[31] != a[31]); end
         3'd6: f = (a < b) ? 32'd1 : 32'd0;
         default: f = (a >= 32) ? 32'd0 : (b << a[4:0]);
      endcase
      return {f, (f == 32'h0), ov};
   endfunction

   // ---------------- scoreboard ----------------
   logic [33:0] exp_q[$];
   int          m_op  = 0;
   int          m_ovf = 0;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   always @(negedge clk) begin
      logic [33:0] r;
      logic        push, pop;
      if (rst) begin
         exp_q.delete();
         m_op  = 0;
         m_ovf = 0;
      end else begin
         check_val("mon_out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
         check_val("mon_in_ready", 32'(bus.in_ready), 32'(exp_q.size() < DEPTH));
         check_val("mon_op_cnt", 32'(op_cnt), 32'(m_op));
         check_val("mon_ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
         if (exp_q.size() != 0) begin
            check_val("mon_out_f", bus.out_f, exp_q[0][33:2]);
            check_val("mon_out_zf", 32'(bus.out_zf), 32'(exp_q[0][1]));
            check_val("mon_out_of", 32'(bus.out_of), 32'(exp_q[0][0]));
         end
         pop  = (exp_q.size() != 0) && bus.out_ready;
         push = bus.in_valid && (exp_q.size() < DEPTH);
         r    = alu_model(bus.in_op, bus.in_a, bus.in_b);
         if (pop) void'(exp_q.pop_front());
         if (push) exp_q.push_back(r);
         if (cnt_clr) begin
            m_op  = 0;
            m_ovf = 0;
         end else if (push) begin
            if (m_op < CNT_MAX) m_op++;
            if (r[0] && (m_ovf < CNT_MAX)) m_ovf++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic got;
      got          = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check_val("accept", 32'(got), 32'd1);
   endtask

   // Single op into an empty, draining FIFO: result visible one cycle after accept.
   task automatic directed_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] f_exp,
                              input logic zf_exp, input logic of_exp);
      drive_op(op, a, b);
      @(negedge clk);
      check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check_val({tag, "_f"}, bus.out_f, f_exp);
      check_val({tag, "_zf"}, 32'(bus.out_zf), 32'(zf_exp));
      check_val({tag, "_of"}, 32'(bus.out_of), 32'(of_exp));
      @(posedge clk);
      #1;
   endtask

   task automatic random_ops(input int n);
      logic [2:0]  op;
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         drive_op(op, a, $urandom);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c0;
      rst           = 1'b1;
      cnt_clr       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = 3'd0;
      bus.in_a      = 32'h0;
      bus.in_b      = 32'h0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check_val("rst_out_f", bus.out_f, 32'h0);
      check_val("rst_out_zf", 32'(bus.out_zf), 32'd0);
      check_val("rst_out_of", 32'(bus.out_of), 32'd0);
      check_val("rst_op_cnt", 32'(op_cnt), 32'd0);
      check_val("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
      @(posedge clk);
      #1;

      directed_op("add_pos_ovf", 3'd4, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1);
      check_val("ovf_cnt_first", 32'(ovf_cnt), 32'd1);
      directed_op("add_neg_ovf", 3'd4, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1);
      directed_op("sub_no_ovf", 3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b0);
      directed_op("sub_ovf", 3'd5, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1);
      directed_op("slt_unsigned", 3'd6, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b1, 1'b0);
      directed_op("slt_true", 3'd6, 32'h1, 32'h2, 32'h1, 1'b0, 1'b0);
      directed_op("sll_3", 3'd7, 32'h3, 32'h607, 32'h3038, 1'b0, 1'b0);
      directed_op("sll_31", 3'd7, 32'd31, 32'h1, 32'h80000000, 1'b0, 1'b0);
      directed_op("sll_32", 3'd7, 32'd32, 32'h1, 32'h0, 1'b1, 1'b0);
      directed_op("and", 3'd0, 32'h12345678, 32'h33332222, 32'h12300220, 1'b0, 1'b0);
      directed_op("or", 3'd1, 32'h0F0F0000, 32'h00F000F0, 32'h0FFF00F0, 1'b0, 1'b0);
      directed_op("xor", 3'd2, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0);
      directed_op("nor", 3'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);

      // Backpressure: two entries fill the FIFO, the third waits for a pop.
      bus.out_ready = 1'b0;
      drive_op(3'd1, 32'h1, 32'h2);
      drive_op(3'd2, 32'h3, 32'h3);
      @(negedge clk);
      check_val("full_in_ready", 32'(bus.in_ready), 32'd0);
      check_val("full_head_f", bus.out_f, 32'h3);
      fork
         drive_op(3'd4, 32'h5, 32'h6);
         begin
            repeat (3) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;

      // Reset with two buffered entries and a coincident request.
      bus.out_ready = 1'b0;
      drive_op(3'd4, 32'h1, 32'h1);
      drive_op(3'd4, 32'h7FFFFFFF, 32'h1);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check_val("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      check_val("midrst_op_cnt", 32'(op_cnt), 32'd0);
      check_val("midrst_ovf_cnt", 32'(ovf_cnt), 32'd0);
      @(posedge clk);
      #1;

      // Clear coincident with an overflowing accept: clear wins.
      drive_op(3'd0, 32'h1, 32'h1);
      drive_op(3'd4, 32'h7FFFFFFF, 32'h1);
      cnt_clr = 1'b1;
      drive_op(3'd4, 32'h7FFFFFFF, 32'h1);
      cnt_clr = 1'b0;
      @(negedge clk);
      check_val("clr_op_cnt", 32'(op_cnt), 32'd0);
      check_val("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);
      @(posedge clk);
      #1;

      // Continuous stream: one accept per cycle.
      c0 = cyc;
      random_ops(100);
      check_val("stream_cycles", 32'(cyc - c0), 32'd100);
      @(negedge clk);
      check_val("stream_op_cnt", 32'(op_cnt), 32'd100);
      @(posedge clk);
      #1;

      random_ops(170);
      @(negedge clk);
      check_val("sat_op_cnt", 32'(op_cnt), 32'(CNT_MAX));
      @(posedge clk);
      #1;

      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check_val("drain", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
